eth_tx_arbiter: RTL



---
 rtl/eth_tx_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arbiter
// Purpose  : Two-source round-robin transmit sequencer for the RGMII byte
//            path. Owns the wire for one frame at a time and emits:
//              preamble (0x55 x PREAMBLE_LEN), SFD (0xD5), the granted
//              source's frame bytes (FCS supplied by the source), then an
//              inter-frame gap of IFG_LEN idle cycles.
//            Frames longer than MAX_FRAME_LEN are cut at that length and
//            flagged with a one-cycle len_err pulse.
// Ports    : eth_txc        - transmit byte clock (rising edge)
//            rst_n          - asynchronous active-low reset
//            src_req[1:0]   - per-source complete-frame-ready level
//            src0/1_data    - per-source FWFT data byte
//            src_last[1:0]  - per-source "current byte is final" flag
//            src_rd[1:0]    - per-source byte consumed this cycle
//            grant[1:0]     - one-hot frame owner, 0 when idle
//            tx_databyte    - registered byte to the DDR stage
//            tx_databyte_en - registered byte valid to the DDR stage
//            busy           - FSM not in IDLE
//            len_err        - one-cycle pulse on length-limit termination
// Options  : ETH_TX_ARB_STATS_EN adds frame_cnt0/frame_cnt1 (16-bit,
//            wrapping) and err_cnt (8-bit, saturating) statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter #(
  parameter int PREAMBLE_LEN  = 7,
  parameter int IFG_LEN       = 12,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic       eth_txc,
  input  logic       rst_n,
  input  logic [1:0] src_req,
  input  logic [7:0] src0_data,
  input  logic [7:0] src1_data,
  input  logic [1:0] src_last,
  output logic [1:0] src_rd,
  output logic [1:0] grant,
  output logic [7:0] tx_databyte,
  output logic       tx_databyte_en,
  output logic       busy,
  output logic       len_err
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_PRE  = 3'd1;
  localparam logic [2:0] c_ST_SFD  = 3'd2;
  localparam logic [2:0] c_ST_DATA = 3'd3;
  localparam logic [2:0] c_ST_IFG  = 3'd4;

  localparam logic [3:0]  c_PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [5:0]  c_IFG_LAST = 6'(IFG_LEN - 1);
  localparam logic [11:0] c_LEN_LAST = 12'(MAX_FRAME_LEN - 1);
  localparam logic [7:0]  c_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  c_SFD_BYTE      = 8'hD5;

  logic [2:0]  r_state;
  logic [1:0]  r_grant;
  logic        r_rr;          // index of the source granted most recently
  logic [3:0]  r_pre_cnt;
  logic [5:0]  r_ifg_cnt;
  logic [11:0] r_byte_cnt;
  logic [7:0]  r_tx_data;
  logic        r_tx_en;
  logic        r_len_err;

  logic        w_win;         // index of the arbitration winner
  logic [1:0]  w_win_onehot;
  logic [7:0]  w_src_byte;
  logic        w_last;
  logic        w_at_limit;
  logic        w_frame_end;

  // On a tie the source that did not own the previous frame wins.
  always_comb begin
    w_win = 1'b0;
    case (src_req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_rr;
      default: w_win = 1'b0;
    endcase
  end

  assign w_win_onehot = w_win ? 2'b10 : 2'b01;
  assign w_src_byte   = r_grant[1] ? src1_data : src0_data;
  assign w_last       = |(src_last & r_grant);
  assign w_at_limit   = (r_byte_cnt == c_LEN_LAST);
  assign w_frame_end  = (r_state == c_ST_DATA) && (w_last || w_at_limit);

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge eth_txc or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_grant    <= 2'b00;
      r_rr       <= 1'b1;
      r_pre_cnt  <= 4'd0;
      r_ifg_cnt  <= 6'd0;
      r_byte_cnt <= 12'd0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (|src_req) begin
            r_grant   <= w_win_onehot;
            r_rr      <= w_win;
            r_pre_cnt <= 4'd0;
            r_state   <= c_ST_PRE;
          end
        end
        c_ST_PRE: begin
          if (r_pre_cnt == c_PRE_LAST) begin
            r_state <= c_ST_SFD;
          end else begin
            r_pre_cnt <= r_pre_cnt + 4'd1;
          end
        end
        c_ST_SFD: begin
          r_byte_cnt <= 12'd0;
          r_state    <= c_ST_DATA;
        end
        c_ST_DATA: begin
          r_byte_cnt <= r_byte_cnt + 12'd1;
          if (w_last || w_at_limit) begin
            // The byte read this cycle is still sent; ownership is dropped
            // immediately so the source can flush any untransmitted tail.
            r_grant   <= 2'b00;
            r_ifg_cnt <= 6'd0;
            r_len_err <= ~w_last;
            r_state   <= c_ST_IFG;
          end
        end
        c_ST_IFG: begin
          if (r_ifg_cnt == c_IFG_LAST) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + 6'd1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output byte register: one cycle behind the state that produces it, so the
  // source byte read in DATA appears on the wire the following cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge eth_txc or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_PRE: begin
          r_tx_data <= c_PREAMBLE_BYTE;
          r_tx_en   <= 1'b1;
        end
        c_ST_SFD: begin
          r_tx_data <= c_SFD_BYTE;
          r_tx_en   <= 1'b1;
        end
        c_ST_DATA: begin
          r_tx_data <= w_src_byte;
          r_tx_en   <= 1'b1;
        end
        default: begin
          r_tx_data <= 8'h00;
          r_tx_en   <= 1'b0;
        end
      endcase
    end
  end

  assign src_rd         = (r_state == c_ST_DATA) ? r_grant : 2'b00;
  assign grant          = r_grant;
  assign tx_databyte    = r_tx_data;
  assign tx_databyte_en = r_tx_en;
  assign busy           = (r_state != c_ST_IDLE);
  assign len_err        = r_len_err;

`ifdef ETH_TX_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics: frame counters wrap, error counter saturates.
  // --------------------------------------------------------------------------
  logic [15:0] r_frame_cnt0;
  logic [15:0] r_frame_cnt1;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge eth_txc or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt0 <= 16'd0;
      r_frame_cnt1 <= 16'd0;
      r_err_cnt    <= 8'd0;
    end else begin
      if (w_frame_end && r_grant[0]) begin
        r_frame_cnt0 <= r_frame_cnt0 + 16'd1;
      end
      if (w_frame_end && r_grant[1]) begin
        r_frame_cnt1 <= r_frame_cnt1 + 16'd1;
      end
      if (r_len_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign frame_cnt0 = r_frame_cnt0;
  assign frame_cnt1 = r_frame_cnt1;
  assign err_cnt    = r_err_cnt;
`endif

endmodule
`default_nettype wire
